// File: rtl/weight_loader.sv
// Weight-stage feeder for the systolic array: buffers one tile, drains it skewed
// to the PE column tops, then ripples a bank-select toggle across the columns.
module weight_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [COLS*DATA_WIDTH-1:0]     s_data_i,
    input  logic                           swap_en_i,
    output logic [COLS*(DATA_WIDTH+2)-1:0] weight_o,
    output logic                           active_bank_o,
    output logic                           busy_o,
    output logic                           tile_done_o
);

    localparam int unsigned STEPS = ROWS + COLS - 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned WW    = DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, WAIT_SWAP, SWAP} state_t;

    state_t                      state_q;
    logic [RW-1:0]               j_q;
    logic [KW-1:0]               k_q;
    logic [CW-1:0]               sw_q;
    logic                        bank_q;
    logic                        s_ready_q;
    logic                        busy_q;
    logic                        done_q;
    logic [COLS*DATA_WIDTH-1:0]  buf_q [ROWS];
    logic [COLS*DATA_WIDTH-1:0]  buf_d [ROWS];
    logic [DATA_WIDTH-1:0]       data_q [COLS];
    logic [DATA_WIDTH-1:0]       data_d [COLS];
    logic [COLS-1:0]             valid_q;
    logic [COLS-1:0]             valid_d;
    logic [COLS-1:0]             sel_q;

    logic hs;
    logic last_beat;
    logic swap_go;
    logic emit;
    int   emit_k;

    // Buffer write-through and next drain word; the word for step 0 is formed
    // on the last-beat edge, so it must see that beat before it is stored.
    always_comb begin
        hs        = s_valid_i && s_ready_q;
        last_beat = hs && (j_q == RW'(ROWS - 1));
        swap_go   = (state_q == WAIT_SWAP) && swap_en_i;
        for (int r = 0; r < int'(ROWS); r++) begin
            buf_d[r] = buf_q[r];
        end
        if (hs) begin
            buf_d[j_q] = s_data_i;
        end
        emit   = last_beat || ((state_q == DRAIN) && (k_q != KW'(STEPS - 1)));
        emit_k = (state_q == DRAIN) ? int'(k_q) + 1 : 0;
        for (int c = 0; c < int'(COLS); c++) begin
            data_d[c]  = '0;
            valid_d[c] = 1'b0;
            if (emit && (emit_k >= c) && ((emit_k - c) < int'(ROWS))) begin
                data_d[c]  = buf_d[RW'(emit_k - c)][c*DATA_WIDTH +: DATA_WIDTH];
                valid_d[c] = 1'b1;
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            j_q       <= '0;
            k_q       <= '0;
            sw_q      <= '0;
            bank_q    <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= '0;
            sel_q     <= '0;
            for (int r = 0; r < int'(ROWS); r++) begin
                buf_q[r] <= '0;
            end
            for (int c = 0; c < int'(COLS); c++) begin
                data_q[c] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(ROWS); r++) begin
                buf_q[r] <= buf_d[r];
            end
            for (int c = 0; c < int'(COLS); c++) begin
                data_q[c] <= data_d[c];
            end
            valid_q <= valid_d;
            // Bank-select skew chain: column c follows column 0 by c cycles.
            sel_q[0] <= bank_q ^ swap_go;
            for (int c = 1; c < int'(COLS); c++) begin
                sel_q[c] <= sel_q[c-1];
            end
            case (state_q)
                IDLE, FILL: begin
                    s_ready_q <= 1'b1;
                    if (hs) begin
                        busy_q <= 1'b1;
                        if (last_beat) begin
                            state_q   <= DRAIN;
                            j_q       <= '0;
                            k_q       <= '0;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q <= FILL;
                            j_q     <= j_q + RW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (k_q == KW'(STEPS - 1)) begin
                        state_q <= WAIT_SWAP;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                WAIT_SWAP: begin
                    if (swap_en_i) begin
                        bank_q  <= ~bank_q;
                        state_q <= SWAP;
                        sw_q    <= '0;
                        done_q  <= (COLS == 1);
                    end
                end
                SWAP: begin
                    if (sw_q == CW'(COLS - 1)) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end else begin
                        sw_q   <= sw_q + CW'(1);
                        done_q <= ((int'(sw_q) + 2) == int'(COLS));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
        assign weight_o[c*WW +: WW] = {data_q[c], sel_q[c], valid_q[c]};
    end

    assign s_ready_o     = s_ready_q;
    assign active_bank_o = bank_q;
    assign busy_o        = busy_q;
    assign tile_done_o   = done_q;

endmodule
